register_file: RTL and testbench
================================

Name: register_file

Overview:
- Parametrised multi-port register file; next generation of the single-enable storage register.
- Provides BIT_COUNT-wide storage for the CPU datapath: one write port and two independent read ports (A, B).
- Includes write-to-read bypass, an optional hardwired zero register, and an optional registered-read stage.
- Holds a per-register busy scoreboard so the decode stage can stall on pending writes.
- Sits between decode (reads, reservations) and writeback (writes).

Parameters:
- BIT_COUNT, 8, data width of each register.
- REG_COUNT, 8, number of registers; must be a power of two and at least 2.
- ADDR_WIDTH, $clog2(REG_COUNT), register address width (derived; do not override).
- ZERO_REG, 1, if 1: register 0 always reads 0, ignores writes and is never busy.
- REGISTERED_READ, 0, if 0: read data is combinational; if 1: read data is registered (1-cycle latency).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  BIT_COUNT  write data.
- rd_en_a  input  1  read enable, port A.
- rd_addr_a  input  ADDR_WIDTH  read address, port A.
- rd_data_a  output  BIT_COUNT  read data, port A.
- busy_a  output  1  scoreboard bit for rd_addr_a.
- rd_en_b, rd_addr_b, rd_data_b, busy_b: same as port A, for port B.
- rsv_en  input  1  reserve (mark busy) strobe from decode.
- rsv_addr  input  ADDR_WIDTH  register to reserve.

Behaviour:
- Reset (rst=1 at posedge):
  - all registers and all busy bits cleared to 0;
  - if REGISTERED_READ=1, rd_data_a/b cleared to 0;
  - writes and reservations in the same cycle are ignored.
- A write is effective when wr_en=1 and not (ZERO_REG=1 and wr_addr=0). It updates the register at the posedge and clears that register's busy bit.
- A reservation is effective when rsv_en=1 and not (ZERO_REG=1 and rsv_addr=0). It sets the busy bit at the posedge.
- Write and reservation to the same address in the same cycle:
  - data is written and the busy bit ends SET;
  - reason: a new producer has been issued, so the reservation wins.
- Reservation of an already-busy register: the bit stays set. No counting.
- Read value, per port:
  - if an effective write in the current cycle matches the read address, the value is wr_data (bypass);
  - otherwise it is the stored register;
  - address 0 with ZERO_REG=1 always gives 0.
- REGISTERED_READ=0:
  - rd_data_x = read value when rd_en_x=1, else 0 (no high-impedance outputs);
  - combinational, 0-cycle latency.
- REGISTERED_READ=1:
  - at each posedge rd_data_x <= (rd_en_x ? read value : 0);
  - the bypass is evaluated in the capture cycle, so data written in cycle N and read in cycle N appears at N+1.
- busy_x, combinational for both modes: busy bit of rd_addr_x, forced to 0 when an effective write in the current cycle matches rd_addr_x. rd_en_x does not gate it.
- Ports A and B may read the same address simultaneously; both return identical data.
- Out-of-range addresses cannot occur (REG_COUNT is a power of two).

Decomposition:
- Shared package cpu_pkg holds:
  - default BIT_COUNT and REG_COUNT constants;
  - a typedef for the register address;
  - a typedef for the data word, reused by ALU and decode.
- One sub-module, register_file_read_port, instantiated twice. It contains:
  - the address mux;
  - the bypass compare;
  - zero-register forcing;
  - the optional output register;
  - the busy lookup.
- Storage, write decode and scoreboard stay in the top module.

Test Plan:
- Reset then read: after rst pulse, read all addresses on A and B with rd_en=1 -> rd_data=0 and busy=0 for every address.
- Write/readback: write 0x5A to r3; next cycle read r3 on A and r3 on B -> both 0x5A. With rd_en_a=0 -> rd_data_a=0.
- Bypass: write 0xC3 to r5 while reading r5 on A in the same cycle.
  - REGISTERED_READ=0: 0xC3 in that cycle.
  - REGISTERED_READ=1: 0xC3 one cycle later.
- Zero register (ZERO_REG=1): write 0xFF to r0 and reserve r0 -> r0 reads 0x00, busy_a=0. Repeat with ZERO_REG=0 -> reads 0xFF, busy=1.
- Scoreboard:
  - reserve r2 -> busy_a(r2)=1 next cycle;
  - write r2=0x11 -> busy forced 0 in the write cycle, 0 afterwards;
  - simultaneous reserve+write r2=0x22 -> data 0x22, busy=1.
- Reset mid-operation: write r4=0x77 and reserve r4, then assert rst together with wr_en (r4=0x99) -> r4 reads 0, busy 0, and the write is discarded.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared CPU datapath definitions: default register-file geometry and the
// address / data-word types used by the register file, ALU and decode.
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int CPU_BIT_COUNT  = 8;
    localparam int CPU_REG_COUNT  = 8;
    localparam int CPU_ADDR_WIDTH = $clog2(CPU_REG_COUNT);

    // Register index at the default geometry.
    typedef logic [CPU_ADDR_WIDTH-1:0] reg_addr_t;

    // Datapath word at the default geometry.
    typedef logic [CPU_BIT_COUNT-1:0] data_word_t;

endpackage : cpu_pkg

// File: rtl/register_file_read_port.sv
// ---------------------------------------------------------------------------
// register_file_read_port
// One read port of the register file: selects the addressed register, applies
// the write-to-read bypass and zero-register forcing, gates by the read
// enable, optionally registers the result, and looks up the busy bit.
//
// Ports:
//   clk, rst      clock / synchronous active-high reset (output register)
//   rd_en         read enable; disabled reads return 0
//   rd_addr       register to read
//   regs          flattened view of all stored registers
//   busy_vec      scoreboard bits, one per register
//   wr_eff        a write is taking effect this cycle
//   wr_addr       address of that write
//   wr_data       data of that write (bypass source)
//   rd_data       read data (combinational or 1-cycle registered)
//   busy          scoreboard bit of rd_addr, cleared by a matching write
// ---------------------------------------------------------------------------
module register_file_read_port
    import cpu_pkg::*;
#(
    parameter int BIT_COUNT       = CPU_BIT_COUNT,
    parameter int REG_COUNT       = CPU_REG_COUNT,
    parameter int ADDR_WIDTH      = $clog2(REG_COUNT),
    parameter bit ZERO_REG        = 1'b1,
    parameter bit REGISTERED_READ = 1'b0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 rd_en,
    input  logic [ADDR_WIDTH-1:0]                rd_addr,
    input  logic [REG_COUNT-1:0][BIT_COUNT-1:0]  regs,
    input  logic [REG_COUNT-1:0]                 busy_vec,
    input  logic                                 wr_eff,
    input  logic [ADDR_WIDTH-1:0]                wr_addr,
    input  logic [BIT_COUNT-1:0]                 wr_data,
    output logic [BIT_COUNT-1:0]                 rd_data,
    output logic                                 busy
);

    logic                 wr_hit_s;
    logic                 zero_hit_s;
    logic [BIT_COUNT-1:0] read_value_s;
    logic [BIT_COUNT-1:0] rd_data_d;
    logic [BIT_COUNT-1:0] rd_data_q;
    logic                 busy_s;

    // Read value selection: zero register, then bypass, then storage.
    always_comb begin
        wr_hit_s     = wr_eff && (wr_addr == rd_addr);
        zero_hit_s   = ZERO_REG && (rd_addr == {ADDR_WIDTH{1'b0}});
        read_value_s = regs[rd_addr];
        // wr_eff already excludes r0 when ZERO_REG is set, so the zero check
        // taking priority is only a belt-and-braces guard.
        if (zero_hit_s) begin
            read_value_s = {BIT_COUNT{1'b0}};
        end else if (wr_hit_s) begin
            read_value_s = wr_data;
        end else begin
            read_value_s = regs[rd_addr];
        end
    end

    // Enable gating and busy lookup; a write landing this cycle retires the
    // pending producer, so busy is already reported clear.
    always_comb begin
        rd_data_d = {BIT_COUNT{1'b0}};
        busy_s    = 1'b0;
        if (rd_en) begin
            rd_data_d = read_value_s;
        end else begin
            rd_data_d = {BIT_COUNT{1'b0}};
        end
        if (zero_hit_s || wr_hit_s) begin
            busy_s = 1'b0;
        end else begin
            busy_s = busy_vec[rd_addr];
        end
    end

    // Output capture register; only feeds rd_data in registered-read mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= {BIT_COUNT{1'b0}};
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = REGISTERED_READ ? rd_data_q : rd_data_d;
    assign busy    = busy_s;

endmodule : register_file_read_port

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
// Multi-port CPU register file: one write port, two read ports (A, B) with
// write-to-read bypass, optional hardwired zero register, optional registered
// read, and a per-register busy scoreboard for decode stalls.
//
// Ports:
//   clk, rst                 clock / synchronous active-high reset
//   wr_en, wr_addr, wr_data  writeback port; clears the busy bit of wr_addr
//   rd_en_a, rd_addr_a       read port A request
//   rd_data_a, busy_a        read port A data and scoreboard bit
//   rd_en_b, rd_addr_b       read port B request
//   rd_data_b, busy_b        read port B data and scoreboard bit
//   rsv_en, rsv_addr         decode reservation; sets the busy bit of rsv_addr
// ---------------------------------------------------------------------------
module register_file
    import cpu_pkg::*;
#(
    parameter  int BIT_COUNT       = CPU_BIT_COUNT,
    parameter  int REG_COUNT       = CPU_REG_COUNT,
    localparam int ADDR_WIDTH      = $clog2(REG_COUNT),
    parameter  bit ZERO_REG        = 1'b1,
    parameter  bit REGISTERED_READ = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [BIT_COUNT-1:0]  wr_data,
    input  logic                  rd_en_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [BIT_COUNT-1:0]  rd_data_a,
    output logic                  busy_a,
    input  logic                  rd_en_b,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [BIT_COUNT-1:0]  rd_data_b,
    output logic                  busy_b,
    input  logic                  rsv_en,
    input  logic [ADDR_WIDTH-1:0] rsv_addr
);

    logic [REG_COUNT-1:0][BIT_COUNT-1:0] regs_d;
    logic [REG_COUNT-1:0][BIT_COUNT-1:0] regs_q;
    logic [REG_COUNT-1:0]                busy_d;
    logic [REG_COUNT-1:0]                busy_q;
    logic                                wr_eff_s;
    logic                                rsv_eff_s;

    // Effective strobes: r0 swallows writes and reservations when hardwired.
    always_comb begin
        wr_eff_s  = 1'b0;
        rsv_eff_s = 1'b0;
        if (ZERO_REG) begin
            wr_eff_s  = wr_en  && (wr_addr  != {ADDR_WIDTH{1'b0}});
            rsv_eff_s = rsv_en && (rsv_addr != {ADDR_WIDTH{1'b0}});
        end else begin
            wr_eff_s  = wr_en;
            rsv_eff_s = rsv_en;
        end
    end

    // Next-state storage and scoreboard. The reservation is applied after
    // the write so that a same-cycle write+reserve leaves the bit set: the
    // newly issued producer is still outstanding.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_eff_s) begin
            regs_d[wr_addr] = wr_data;
            busy_d[wr_addr] = 1'b0;
        end else begin
            regs_d = regs_q;
        end
        if (rsv_eff_s) begin
            busy_d[rsv_addr] = 1'b1;
        end else begin
            busy_d[0] = busy_d[0];
        end
    end

    // State registers; reset discards any same-cycle write or reservation.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: {BIT_COUNT{1'b0}}};
            busy_q <= {REG_COUNT{1'b0}};
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    register_file_read_port #(
        .BIT_COUNT       (BIT_COUNT),
        .REG_COUNT       (REG_COUNT),
        .ADDR_WIDTH      (ADDR_WIDTH),
        .ZERO_REG        (ZERO_REG),
        .REGISTERED_READ (REGISTERED_READ)
    ) u_port_a (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en_a),
        .rd_addr  (rd_addr_a),
        .regs     (regs_q),
        .busy_vec (busy_q),
        .wr_eff   (wr_eff_s),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data_a),
        .busy     (busy_a)
    );

    register_file_read_port #(
        .BIT_COUNT       (BIT_COUNT),
        .REG_COUNT       (REG_COUNT),
        .ADDR_WIDTH      (ADDR_WIDTH),
        .ZERO_REG        (ZERO_REG),
        .REGISTERED_READ (REGISTERED_READ)
    ) u_port_b (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en_b),
        .rd_addr  (rd_addr_b),
        .regs     (regs_q),
        .busy_vec (busy_q),
        .wr_eff   (wr_eff_s),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data_b),
        .busy     (busy_b)
    );

endmodule : register_file

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
// Directed bench. Two instances share one stimulus stream:
//   c_* : ZERO_REG=1, REGISTERED_READ=0 (combinational read)
//   r_* : ZERO_REG=0, REGISTERED_READ=1 (registered read)
// Inputs change 1 time unit after a rising edge; combinational outputs are
// checked 1 unit later, registered outputs right after the capturing edge.
// ---------------------------------------------------------------------------
module tb_register_file;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en_a;
    logic [2:0] rd_addr_a;
    logic       rd_en_b;
    logic [2:0] rd_addr_b;
    logic       rsv_en;
    logic [2:0] rsv_addr;

    logic [7:0] c_rd_a;
    logic [7:0] c_rd_b;
    logic       c_busy_a;
    logic       c_busy_b;
    logic [7:0] r_rd_a;
    logic [7:0] r_rd_b;
    logic       r_busy_a;
    logic       r_busy_b;

    int n_tests;
    int n_fail;

    register_file #(
        .BIT_COUNT       (8),
        .REG_COUNT       (8),
        .ZERO_REG        (1'b1),
        .REGISTERED_READ (1'b0)
    ) dut_c (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en_a   (rd_en_a),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (c_rd_a),
        .busy_a    (c_busy_a),
        .rd_en_b   (rd_en_b),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (c_rd_b),
        .busy_b    (c_busy_b),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr)
    );

    register_file #(
        .BIT_COUNT       (8),
        .REG_COUNT       (8),
        .ZERO_REG        (1'b0),
        .REGISTERED_READ (1'b1)
    ) dut_r (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en_a   (rd_en_a),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (r_rd_a),
        .busy_a    (r_busy_a),
        .rd_en_b   (rd_en_b),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (r_rd_b),
        .busy_b    (r_busy_b),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = 3'd0;
        wr_data   = 8'h00;
        rd_en_a   = 1'b0;
        rd_addr_a = 3'd0;
        rd_en_b   = 1'b0;
        rd_addr_b = 3'd0;
        rsv_en    = 1'b0;
        rsv_addr  = 3'd0;
        tick();
        tick();
        rst = 1'b0;
        check_val("rst_r_rd_a", r_rd_a, 8'h00);

        // Reset state: every address reads 0 and is not busy.
        rd_en_a = 1'b1;
        rd_en_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i);
            rd_addr_b = 3'(7 - i);
            #1;
            check_val("rst_c_rd_a", c_rd_a, 8'h00);
            check_val("rst_c_rd_b", c_rd_b, 8'h00);
            check_val("rst_c_busy_a", {7'd0, c_busy_a}, 8'h00);
            check_val("rst_c_busy_b", {7'd0, c_busy_b}, 8'h00);
            check_val("rst_r_busy_a", {7'd0, r_busy_a}, 8'h00);
            tick();
            check_val("rst_r_rd_a", r_rd_a, 8'h00);
            check_val("rst_r_rd_b", r_rd_b, 8'h00);
        end

        // Write r3 = 0x5A, then read it on both ports.
        rd_addr_a = 3'd0;
        rd_addr_b = 3'd0;
        wr_en     = 1'b1;
        wr_addr   = 3'd3;
        wr_data   = 8'h5A;
        tick();
        wr_en     = 1'b0;
        rd_addr_a = 3'd3;
        rd_addr_b = 3'd3;
        #1;
        check_val("wr_c_rd_a", c_rd_a, 8'h5A);
        check_val("wr_c_rd_b", c_rd_b, 8'h5A);
        tick();
        check_val("wr_r_rd_a", r_rd_a, 8'h5A);
        check_val("wr_r_rd_b", r_rd_b, 8'h5A);
        rd_en_a = 1'b0;
        #1;
        check_val("dis_c_rd_a", c_rd_a, 8'h00);
        check_val("dis_c_rd_b", c_rd_b, 8'h5A);
        tick();
        check_val("dis_r_rd_a", r_rd_a, 8'h00);
        check_val("dis_r_rd_b", r_rd_b, 8'h5A);

        // Bypass: write r5 = 0xC3 while reading r5 on A.
        rd_en_a   = 1'b1;
        rd_addr_a = 3'd5;
        wr_en     = 1'b1;
        wr_addr   = 3'd5;
        wr_data   = 8'hC3;
        #1;
        check_val("byp_c_rd_a", c_rd_a, 8'hC3);
        check_val("byp_r_rd_a_pre", r_rd_a, 8'h00);
        tick();
        wr_en = 1'b0;
        #1;
        check_val("byp_r_rd_a", r_rd_a, 8'hC3);
        check_val("byp_c_rd_a_after", c_rd_a, 8'hC3);

        // Zero register: write 0xFF to r0 and reserve r0.
        rd_addr_a = 3'd0;
        wr_en     = 1'b1;
        wr_addr   = 3'd0;
        wr_data   = 8'hFF;
        rsv_en    = 1'b1;
        rsv_addr  = 3'd0;
        tick();
        wr_en  = 1'b0;
        rsv_en = 1'b0;
        #1;
        check_val("zero_c_rd_a", c_rd_a, 8'h00);
        check_val("zero_c_busy_a", {7'd0, c_busy_a}, 8'h00);
        check_val("zero_r_busy_a", {7'd0, r_busy_a}, 8'h01);
        check_val("zero_r_rd_a_byp", r_rd_a, 8'hFF);
        tick();
        check_val("zero_r_rd_a", r_rd_a, 8'hFF);

        // Scoreboard on r2.
        rd_addr_a = 3'd2;
        rd_addr_b = 3'd2;
        rsv_en    = 1'b1;
        rsv_addr  = 3'd2;
        tick();
        rsv_en = 1'b0;
        #1;
        check_val("sb_rsv_c_busy_a", {7'd0, c_busy_a}, 8'h01);
        check_val("sb_rsv_c_busy_b", {7'd0, c_busy_b}, 8'h01);
        check_val("sb_rsv_r_busy_a", {7'd0, r_busy_a}, 8'h01);
        wr_en   = 1'b1;
        wr_addr = 3'd2;
        wr_data = 8'h11;
        #1;
        check_val("sb_wr_c_busy_a", {7'd0, c_busy_a}, 8'h00);
        check_val("sb_wr_r_busy_a", {7'd0, r_busy_a}, 8'h00);
        check_val("sb_wr_c_rd_a", c_rd_a, 8'h11);
        tick();
        wr_en = 1'b0;
        #1;
        check_val("sb_post_c_busy_a", {7'd0, c_busy_a}, 8'h00);
        check_val("sb_post_r_busy_a", {7'd0, r_busy_a}, 8'h00);
        check_val("sb_post_r_rd_a", r_rd_a, 8'h11);
        wr_en    = 1'b1;
        wr_addr  = 3'd2;
        wr_data  = 8'h22;
        rsv_en   = 1'b1;
        rsv_addr = 3'd2;
        #1;
        check_val("sb_both_c_busy_now", {7'd0, c_busy_a}, 8'h00);
        tick();
        wr_en  = 1'b0;
        rsv_en = 1'b0;
        #1;
        check_val("sb_both_c_busy_a", {7'd0, c_busy_a}, 8'h01);
        check_val("sb_both_r_busy_a", {7'd0, r_busy_a}, 8'h01);
        check_val("sb_both_c_rd_a", c_rd_a, 8'h22);
        check_val("sb_both_c_rd_b", c_rd_b, 8'h22);
        check_val("sb_both_r_rd_a", r_rd_a, 8'h22);

        // Reset in the middle of operation on r4.
        rd_addr_a = 3'd4;
        wr_en     = 1'b1;
        wr_addr   = 3'd4;
        wr_data   = 8'h77;
        rsv_en    = 1'b1;
        rsv_addr  = 3'd4;
        tick();
        wr_en  = 1'b0;
        rsv_en = 1'b0;
        #1;
        check_val("mid_c_rd_a", c_rd_a, 8'h77);
        check_val("mid_c_busy_a", {7'd0, c_busy_a}, 8'h01);
        check_val("mid_r_busy_a", {7'd0, r_busy_a}, 8'h01);
        rst     = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 3'd4;
        wr_data = 8'h99;
        tick();
        rst   = 1'b0;
        wr_en = 1'b0;
        #1;
        check_val("mrst_c_rd_a", c_rd_a, 8'h00);
        check_val("mrst_c_busy_a", {7'd0, c_busy_a}, 8'h00);
        check_val("mrst_r_busy_a", {7'd0, r_busy_a}, 8'h00);
        check_val("mrst_r_rd_a", r_rd_a, 8'h00);
        check_val("mrst_c_rd_b_r2", c_rd_b, 8'h00);
        tick();
        check_val("mrst_r_rd_a_next", r_rd_a, 8'h00);
        check_val("mrst_r_busy_b", {7'd0, r_busy_b}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_register_file
